// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request, memory-port and response signals of the load/store memory controller
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_width, req_unsigned, req_be, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_width, req_unsigned, req_be, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store memory controller with ack timeout; LSU_MISALIGN_TRAP_EN enables the misalignment trap
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    lsu_mem_ctrl_if.master   bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic [1:0]  width_q;
    logic        uns_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [7:0]  wait_cnt;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        bad_req;
    logic        misalign;
    logic [31:0] wdata_rep;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((bus.req_width == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_width == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        wdata_rep = bus.req_wdata;
        case (bus.req_width)
            2'b00:   wdata_rep = {4{bus.req_wdata[7:0]}};
            2'b01:   wdata_rep = {2{bus.req_wdata[15:0]}};
            default: wdata_rep = bus.req_wdata;
        endcase
    end

    // Extraction runs off the registered offset so it lines up with the ack cycle.
    always_comb begin
        byte_sel = bus.mem_rdata[7:0];
        case (addr_q[1:0])
            2'b00: byte_sel = bus.mem_rdata[7:0];
            2'b01: byte_sel = bus.mem_rdata[15:8];
            2'b10: byte_sel = bus.mem_rdata[23:16];
            2'b11: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (width_q)
            2'b00:   load_ext = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        bad_req    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    bad_req    = (bus.req_width == 2'b11) || misalign;
                    state_next = bad_req ? RESP : REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack || (wait_cnt == TO_LIM))
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            width_q  <= 2'b00;
            uns_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            wait_cnt <= 8'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept && bad_req) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end else if (accept) begin
                        addr_q   <= bus.req_addr;
                        width_q  <= bus.req_width;
                        uns_q    <= bus.req_unsigned;
                        we_q     <= bus.req_we;
                        be_q     <= bus.req_we ? bus.req_be : 4'h0;
                        wdata_q  <= wdata_rep;
                        wait_cnt <= 8'h0;
                    end
                end
                REQ: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (bus.mem_ack) begin
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? 32'h0 : load_ext;
                    end else if (wait_cnt == TO_LIM) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic we, input logic [31:0] addr, input logic [1:0] width,
                         input logic uns, input logic [3:0] be, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_width    = width;
        bus.req_unsigned = uns;
        bus.req_be       = be;
        bus.req_wdata    = wdata;
        tick();
        bus.req_valid    = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_width    = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_be       = 4'h0;
        bus.req_wdata    = 32'h0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 32'h0;
        tick();
        tick();
        chk("rst_mem_req",   32'(bus.mem_req), 32'h0);
        chk("rst_mem_we",    32'(bus.mem_we), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_err",   32'(bus.rsp_err), 32'h0);
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        chk("rst_mem_be",    32'(bus.mem_be), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);

        // store word, ack in the first REQ cycle
        start(1'b1, 32'h100, 2'b10, 1'b0, 4'hF, 32'hDEADBEEF);
        chk("sw_mem_req",   32'(bus.mem_req), 32'h1);
        chk("sw_mem_addr",  bus.mem_addr, 32'h100);
        chk("sw_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("sw_mem_we",    32'(bus.mem_we), 32'h1);
        chk("sw_mem_be",    32'(bus.mem_be), 32'hF);
        chk("sw_req_ready", 32'(bus.req_ready), 32'h0);
        chk("sw_no_early",  32'(bus.rsp_valid), 32'h0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("sw_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("sw_rsp_err",   32'(bus.rsp_err), 32'h0);
        chk("sw_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("sw_req_drop",  32'(bus.mem_req), 32'h0);
        tick();
        chk("sw_pulse_end", 32'(bus.rsp_valid), 32'h0);
        chk("sw_ready",     32'(bus.req_ready), 32'h1);

        // load byte signed, offset 3
        start(1'b0, 32'h203, 2'b00, 1'b0, 4'h8, 32'h0);
        chk("lb_mem_addr", bus.mem_addr, 32'h200);
        chk("lb_mem_be",   32'(bus.mem_be), 32'h0);
        chk("lb_mem_we",   32'(bus.mem_we), 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h80112233;
        tick();
        bus.mem_ack = 1'b0;
        chk("lb_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("lb_rsp_rdata", bus.rsp_rdata, 32'hFFFFFF80);
        tick();

        // load byte unsigned, same access
        start(1'b0, 32'h203, 2'b00, 1'b1, 4'h8, 32'h0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("lbu_rsp_rdata", bus.rsp_rdata, 32'h00000080);
        tick();

        // store half, ack arrives in the third REQ cycle
        start(1'b1, 32'h302, 2'b01, 1'b0, 4'hC, 32'h0000ABCD);
        chk("sh_mem_wdata", bus.mem_wdata, 32'hABCDABCD);
        chk("sh_mem_be",    32'(bus.mem_be), 32'hC);
        chk("sh_mem_addr",  bus.mem_addr, 32'h300);
        tick();
        tick();
        chk("sh_still_req", 32'(bus.mem_req), 32'h1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("sh_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("sh_rsp_err",   32'(bus.rsp_err), 32'h0);
        tick();

        // load half signed from the upper half, then load word
        start(1'b0, 32'h202, 2'b01, 1'b0, 4'hC, 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h80017FFF;
        tick();
        bus.mem_ack = 1'b0;
        chk("lh_rsp_rdata", bus.rsp_rdata, 32'hFFFF8001);
        tick();
        start(1'b0, 32'h204, 2'b10, 1'b0, 4'hF, 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_ack = 1'b0;
        chk("lw_rsp_rdata", bus.rsp_rdata, 32'h12345678);
        tick();

        // timeout: mem_req high for 5 cycles, then error response
        start(1'b0, 32'h400, 2'b10, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("to_req_%0d", i), 32'(bus.mem_req), 32'h1);
            chk($sformatf("to_norsp_%0d", i), 32'(bus.rsp_valid), 32'h0);
            tick();
        end
        chk("to_req_drop",  32'(bus.mem_req), 32'h0);
        chk("to_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("to_rsp_err",   32'(bus.rsp_err), 32'h1);
        chk("to_rsp_rdata", bus.rsp_rdata, 32'h0);
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("late_ack_0", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("late_ack_1", 32'(bus.rsp_valid), 32'h0);
        chk("late_ack_rdy", 32'(bus.req_ready), 32'h1);

        // ack in the same cycle the counter reaches the limit wins
        start(1'b0, 32'h500, 2'b10, 1'b0, 4'hF, 32'h0);
        tick();
        tick();
        tick();
        tick();
        chk("lim_still_req", 32'(bus.mem_req), 32'h1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_ack = 1'b0;
        chk("lim_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("lim_rsp_err",   32'(bus.rsp_err), 32'h0);
        chk("lim_rsp_rdata", bus.rsp_rdata, 32'hCAFEF00D);
        tick();

        // illegal width goes straight to an error response
        start(1'b0, 32'h600, 2'b11, 1'b0, 4'hF, 32'h0);
        chk("ill_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("ill_rsp_err",   32'(bus.rsp_err), 32'h1);
        chk("ill_mem_req",   32'(bus.mem_req), 32'h0);
        chk("ill_rsp_rdata", bus.rsp_rdata, 32'h0);
        tick();
        chk("ill_ready", 32'(bus.req_ready), 32'h1);

        // misaligned load half at 0x101
        start(1'b0, 32'h101, 2'b01, 1'b0, 4'h3, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("mis_rsp_err",   32'(bus.rsp_err), 32'h1);
        chk("mis_mem_req",   32'(bus.mem_req), 32'h0);
        tick();
`else
        chk("mis_mem_req",  32'(bus.mem_req), 32'h1);
        chk("mis_mem_addr", bus.mem_addr, 32'h100);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234F00D;
        tick();
        bus.mem_ack = 1'b0;
        chk("mis_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("mis_rsp_err",   32'(bus.rsp_err), 32'h0);
        chk("mis_rsp_rdata", bus.rsp_rdata, 32'hFFFFF00D);
        tick();
`endif

        // reset while in REQ drops the transaction
        start(1'b1, 32'h700, 2'b10, 1'b0, 4'hF, 32'h11223344);
        chk("mr_in_req", 32'(bus.mem_req), 32'h1);
        rst = 1'b1;
        tick();
        chk("mr_req_low", 32'(bus.mem_req), 32'h0);
        chk("mr_no_rsp",  32'(bus.rsp_valid), 32'h0);
        rst = 1'b0;
        tick();
        chk("mr_ready",   32'(bus.req_ready), 32'h1);
        chk("mr_no_rsp2", 32'(bus.rsp_valid), 32'h0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("mr_ack_ign0", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("mr_ack_ign1", 32'(bus.rsp_valid), 32'h0);
        chk("mr_req_idle", 32'(bus.mem_req), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
